// File: rtl/fifo_wrapper_pkg.sv
// ----------------------------------------------------------------------------
// fifo_wrapper_pkg
// Shared types and helpers for the fifo_wrapper block.
//   op_e     : per-cycle handshake outcome, encoded as {pop, push}
//   ptr_inc  : ring-pointer increment that wraps from depth-1 back to 0,
//              so DEPTH does not have to be a power of two
// ----------------------------------------------------------------------------
package fifo_wrapper_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        if (ptr == (depth - 32'd1)) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// ----------------------------------------------------------------------------
// fifo_ram
// DEPTH x WIDTH storage array: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//   clk    : write clock (rising edge)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, combinational from raddr
// ----------------------------------------------------------------------------
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [0:DEPTH-1];

    // Storage write port: one word per rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_wrapper.sv
// ----------------------------------------------------------------------------
// fifo_wrapper
// First-word-fall-through FIFO with valid/ready handshakes on both sides.
// A word pushed at edge N is visible at the output after edge N; there is no
// same-cycle bypass. Flags are decoded from the registered occupancy only, so
// there is no combinational path between the two handshake sides.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset (clears pointers and count)
//   input_data   : write data
//   input_valid  : producer offers input_data
//   input_ready  : FIFO can accept a word (count < DEPTH)
//   output_data  : head-of-queue word (don't-care while output_valid=0)
//   output_valid : head word valid (count != 0)
//   output_ready : consumer accepts the head word
//   count        : occupancy, only present when FIFO_WRAPPER_COUNT_EN is defined
//
// Build option: define FIFO_WRAPPER_COUNT_EN to expose the occupancy port.
// ----------------------------------------------------------------------------
module fifo_wrapper
    import fifo_wrapper_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_data,
    input  logic             input_valid,
    output logic             input_ready,
    output logic [WIDTH-1:0] output_data,
    output logic             output_valid,
    input  logic             output_ready
`ifdef FIFO_WRAPPER_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             push_s;
    logic             pop_s;
    op_e              op_s;

    // Flags come from the occupancy register alone; a pop while full does
    // not open input_ready until the following cycle.
    assign input_ready  = (count_r < CNT_W'(DEPTH));
    assign output_valid = (count_r != CNT_W'(0));
    assign push_s       = input_valid && input_ready;
    assign pop_s        = output_valid && output_ready;

`ifdef FIFO_WRAPPER_COUNT_EN
    assign count = count_r;
`endif

    // Next-state for both ring pointers and the occupancy counter.
    always_comb begin
        op_s         = op_e'({pop_s, push_s});
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;

        if (push_s) begin
            wr_ptr_nxt_s = PTR_W'(ptr_inc(32'(wr_ptr_r), 32'(DEPTH)));
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = PTR_W'(ptr_inc(32'(rd_ptr_r), 32'(DEPTH)));
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        case (op_s)
            OP_PUSH: count_nxt_s = count_r + CNT_W'(1);
            OP_POP:  count_nxt_s = count_r - CNT_W'(1);
            OP_BOTH: count_nxt_s = count_r;
            OP_IDLE: count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; reset drops all stored words at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (input_data),
        .raddr (rd_ptr_r),
        .rdata (output_data)
    );

endmodule

// File: tb/tb_fifo_wrapper.sv
// ----------------------------------------------------------------------------
// tb_fifo_wrapper
// Self-checking bench for fifo_wrapper (WIDTH=8, DEPTH=128). A queue model
// records every accepted word and is compared against each word the DUT
// delivers; occupancy flags are compared against the model size each cycle.
// ----------------------------------------------------------------------------
module tb_fifo_wrapper;

    localparam int WIDTH = 8;
    localparam int DEPTH = 128;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] input_data;
    logic             input_valid;
    logic             input_ready;
    logic [WIDTH-1:0] output_data;
    logic             output_valid;
    logic             output_ready;
`ifdef FIFO_WRAPPER_COUNT_EN
    logic [7:0]       count;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] q[$];

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[7];

    fifo_wrapper #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready)
`ifdef FIFO_WRAPPER_COUNT_EN
        ,
        .count        (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle with inputs already driven: model the handshakes,
    // step past the edge, then compare the flags against the model.
    task automatic cycle(output bit pushed);
        bit popped;
        logic [WIDTH-1:0] exp_word;
        #1;
        pushed = input_valid && input_ready && !reset;
        popped = output_valid && output_ready && !reset;
        if (popped) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got pop with data %0h expected no pop", output_data);
            end else begin
                exp_word = q.pop_front();
                chk("sb_data", 32'(output_data), 32'(exp_word));
            end
        end
        if (pushed) q.push_back(input_data);
        @(posedge clk);
        #1;
        chk("sb_ov", 32'(output_valid), 32'(q.size() != 0));
        chk("sb_ir", 32'(input_ready), 32'(q.size() < DEPTH));
`ifdef FIFO_WRAPPER_COUNT_EN
        chk("sb_count", 32'(count), 32'(q.size()));
`endif
    endtask

    task automatic step();
        bit b;
        cycle(b);
    endtask

    task automatic drain(input string name);
        int n;
        input_valid  = 1'b0;
        output_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        chk(name, 32'(q.size()), 32'd0);
        output_ready = 1'b0;
    endtask

    initial begin
        int sent;
        bit p;

        // iv, d, ordy -> expected ir, ov, head data after the edge
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
        vecs[5] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

        reset        = 1'b1;
        input_valid  = 1'b0;
        input_data   = 8'h00;
        output_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ir", 32'(input_ready), 32'd1);
        chk("reset_ov", 32'(output_valid), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_ir", 32'(input_ready), 32'd1);
        chk("idle_ov", 32'(output_valid), 32'd0);
`ifdef FIFO_WRAPPER_COUNT_EN
        chk("idle_count", 32'(count), 32'd0);
`endif

        // No same-cycle bypass: offering into an empty FIFO leaves valid low
        input_valid = 1'b1;
        input_data  = 8'hA5;
        #2;
        chk("no_bypass", 32'(output_valid), 32'd0);
        input_valid = 1'b0;
        #1;

        // Table-driven single-word sequences
        for (int i = 0; i < 7; i++) begin
            input_valid  = vecs[i].iv;
            input_data   = vecs[i].d;
            output_ready = vecs[i].ordy;
            step();
            chk($sformatf("vec%0d_ir", i), 32'(input_ready), 32'(vecs[i].exp_ir));
            chk($sformatf("vec%0d_ov", i), 32'(output_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                chk($sformatf("vec%0d_data", i), 32'(output_data), 32'(vecs[i].exp_d));
            end
        end

        // Fill to capacity
        output_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            input_valid = 1'b1;
            input_data  = 8'(i);
            step();
        end
        chk("full_ir", 32'(input_ready), 32'd0);
        chk("full_ov", 32'(output_valid), 32'd1);

        // 129th word is dropped
        input_data = 8'hFF;
        step();
        chk("drop_size", 32'(q.size()), 32'd128);
        chk("drop_head", 32'(output_data), 32'd0);

        // Push and pop offered together while full: only the pop happens
        input_data   = 8'hEE;
        output_ready = 1'b1;
        step();
        chk("fullpop_ir", 32'(input_ready), 32'd1);
        chk("fullpop_size", 32'(q.size()), 32'd127);
        chk("fullpop_head", 32'(output_data), 32'd1);
`ifdef FIFO_WRAPPER_COUNT_EN
        chk("fullpop_count", 32'(count), 32'd127);
`endif
        drain("drain_full");

        // Random stream with random handshakes, wraps both pointers
        sent = 0;
        for (int cyc = 0; cyc < 5000 && (sent < 300 || q.size() != 0); cyc++) begin
            input_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
            input_data   = 8'($urandom);
            output_ready = ($urandom_range(0, 2) != 0);
            cycle(p);
            if (p) sent++;
        end
        chk("stream_sent", 32'(sent), 32'd300);
        chk("stream_empty", 32'(q.size()), 32'd0);

        // Reset mid-cycle with 5 words held
        output_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            input_valid = 1'b1;
            input_data  = 8'(8'h10 + i);
            step();
        end
        input_valid = 1'b0;
        chk("pre_reset_ov", 32'(output_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_ov", 32'(output_valid), 32'd0);
        chk("async_reset_ir", 32'(input_ready), 32'd1);
        q.delete();
        // Handshakes offered during reset are ignored
        input_valid  = 1'b1;
        input_data   = 8'h99;
        output_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("in_reset_ov", 32'(output_valid), 32'd0);
        #3;
        reset        = 1'b0;
        input_valid  = 1'b0;
        output_ready = 1'b0;
        step();
        chk("post_reset_ov", 32'(output_valid), 32'd0);
        input_valid = 1'b1;
        input_data  = 8'h5A;
        step();
        input_valid = 1'b0;
        chk("post_reset_data", 32'(output_data), 32'h5A);
        drain("drain_post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
